// File: rtl/addsub_arb.sv
// Round-robin arbiter that lets two requesters share one W-bit adder/subtracter.
// The result is held in a single output register together with flags and the issuer ID.
module addsub_arb #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_sub,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_sub,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_y,
    output logic         res_id,
    output logic         res_cout,
    output logic         res_ovf
);

    logic         last_q;
    logic         valid_q;
    logic [W-1:0] y_q;
    logic         id_q;
    logic         cout_q;
    logic         ovf_q;

    logic         can_accept;
    logic         acc0;
    logic         acc1;
    logic         accept;
    logic         sel_sub;
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic [W:0]   sum;
    logic         ovf;

    always_comb begin
        can_accept = rst_n & (~valid_q | res_ready);
        // Each ready looks only at the other port's valid, so a port is ready whenever
        // it would win if it asserted valid; no combinational path from its own valid.
        req0_ready = can_accept & (last_q | ~req1_valid);
        req1_ready = can_accept & (~last_q | ~req0_valid);
        acc0       = req0_ready & req0_valid;
        acc1       = req1_ready & req1_valid;
        accept     = acc0 | acc1;
        sel_a      = acc1 ? req1_a   : req0_a;
        sel_b      = acc1 ? req1_b   : req0_b;
        sel_sub    = acc1 ? req1_sub : req0_sub;
        // Top bit of the zero-extended difference is the borrow.
        sum        = sel_sub ? ({1'b0, sel_a} - {1'b0, sel_b})
                             : ({1'b0, sel_a} + {1'b0, sel_b});
        if (sel_sub) begin
            ovf = (sel_a[W-1] != sel_b[W-1]) && (sum[W-1] != sel_a[W-1]);
        end else begin
            ovf = (sel_a[W-1] == sel_b[W-1]) && (sum[W-1] != sel_a[W-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= 1'b1;
            valid_q <= 1'b0;
            y_q     <= '0;
            id_q    <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            last_q  <= acc1;
            valid_q <= 1'b1;
            y_q     <= sum[W-1:0];
            id_q    <= acc1;
            cout_q  <= sum[W];
            ovf_q   <= ovf;
        end else if (res_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign res_valid = valid_q;
    assign res_y     = y_q;
    assign res_id    = id_q;
    assign res_cout  = cout_q;
    assign res_ovf   = ovf_q;

endmodule

// File: tb/tb_addsub_arb.sv
// Bench for addsub_arb: an arithmetic-level model checked every cycle on the falling
// edge, plus directed vectors with literal expectations.
module tb_addsub_arb;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req0_sub = 1'b0;
    logic         req1_valid = 1'b0, req1_sub = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready;
    logic         res_valid, res_id, res_cout, res_ovf;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_y;

    int checks = 0;
    int errors = 0;

    addsub_arb #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_sub(req1_sub),
        .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y), .res_id(res_id),
        .res_cout(res_cout), .res_ovf(res_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: the held result and which requester was served last.
    bit exp_valid = 0, exp_id = 0, exp_cout = 0, exp_ovf = 0, exp_last = 1;
    int exp_y = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_valid = 0; exp_y = 0; exp_id = 0; exp_cout = 0; exp_ovf = 0; exp_last = 1;
        end else begin
            bit can, who, sub;
            int a, b, sa, sb, r, sr;
            can = !exp_valid || res_ready;
            if (can && (req0_valid || req1_valid)) begin
                who = (req0_valid && req1_valid) ? !exp_last : req1_valid;
                a   = who ? int'(req1_a) : int'(req0_a);
                b   = who ? int'(req1_b) : int'(req0_b);
                sub = who ? req1_sub : req0_sub;
                sa  = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
                sb  = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
                r   = sub ? a - b : a + b;
                sr  = sub ? sa - sb : sa + sb;
                exp_y     = r & ((1 << W) - 1);
                exp_cout  = sub ? (a < b) : (r >= (1 << W));
                exp_ovf   = (sr >= (1 << (W - 1))) || (sr < -(1 << (W - 1)));
                exp_id    = who;
                exp_last  = who;
                exp_valid = 1;
            end else if (res_ready) begin
                exp_valid = 0;
            end
        end
    end

    // A port is ready when the unit can take work and that port would win if valid.
    always @(negedge clk) begin
        bit can;
        can = rst_n && (!exp_valid || res_ready);
        check("res_valid", res_valid, exp_valid);
        check("res_y", res_y, exp_y);
        check("res_id", res_id, exp_id);
        check("res_cout", res_cout, exp_cout);
        check("res_ovf", res_ovf, exp_ovf);
        check("req0_ready", req0_ready, can && (!req1_valid || exp_last));
        check("req1_ready", req1_ready, can && (!req0_valid || !exp_last));
        if (req0_valid && req1_valid)
            check("one_ready", req0_ready + req1_ready, can ? 1 : 0);
    end

    task automatic drive(input bit v0, input int a0, input int b0, input bit s0,
                         input bit v1, input int a1, input int b1, input bit s1);
        req0_valid = v0; req0_a = a0[W-1:0]; req0_b = b0[W-1:0]; req0_sub = s0;
        req1_valid = v1; req1_a = a1[W-1:0]; req1_b = b1[W-1:0]; req1_sub = s1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string tag, input bit v, input int y, input bit id,
                       input bit co, input bit ov);
        check({tag, ".valid"}, res_valid, v);
        check({tag, ".y"}, res_y, y);
        check({tag, ".id"}, res_id, id);
        check({tag, ".cout"}, res_cout, co);
        check({tag, ".ovf"}, res_ovf, ov);
    endtask

    initial begin
        int n0, n1;
        #3;
        lit("reset", 0, 0, 0, 0, 0);
        check("reset.ready0", req0_ready, 0);
        check("reset.ready1", req1_ready, 0);
        #9 rst_n = 1'b1;

        step();
        res_ready = 1'b1;
        drive(1, 'h05, 'h03, 0, 0, 0, 0, 0);
        step(); lit("add", 1, 'h08, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 'h7F, 'h01, 0);
        step(); lit("add_ovf", 1, 'h80, 1, 0, 1);
        drive(1, 'hFF, 'h01, 0, 0, 0, 0, 0);
        step(); lit("add_carry", 1, 'h00, 0, 1, 0);
        drive(1, 'h80, 'h01, 1, 0, 0, 0, 0);
        step(); lit("sub_ovf", 1, 'h7F, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 'h03, 'h05, 1);
        step(); lit("sub_borrow", 1, 'hFE, 1, 1, 0);

        // Contention: last served was 1, so requester 0 leads.
        n0 = 0; n1 = 0;
        drive(1, 'h20, 'h01, 0, 1, 'h40, 'h02, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr.id", res_id, i % 2);
            check("rr.y", res_y, (i % 2) ? 'h3E + n1 : 'h21 + n0);
            if (i % 2) n1++; else n0++;
            drive(1, 'h20 + n0, 'h01, 0, 1, 'h40 + n1, 'h02, 1);
        end

        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            lit("bp", 1, 'h40, 1, 0, 0);
            check("bp.ready0", req0_ready, 0);
            check("bp.ready1", req1_ready, 0);
        end
        res_ready = 1'b1;
        step(); lit("drain_accept", 1, 'h24, 0, 0, 0);
        n0++;
        drive(1, 'h20 + n0, 'h01, 0, 1, 'h40 + n1, 'h02, 1);

        #1 rst_n = 1'b0;
        #1;
        lit("mid_reset", 0, 0, 0, 0, 0);
        check("mid_reset.ready0", req0_ready, 0);
        check("mid_reset.ready1", req1_ready, 0);
        #4 rst_n = 1'b1;
        step(); lit("after_reset", 1, 'h25, 0, 0, 0);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(); check("idle.valid", res_valid, 0);
        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_arb.md
# addsub_arb

Round-robin arbiter and sequencer that lets two requesters share one W-bit adder/subtracter. Each requester presents operands and an add/subtract select on a valid/ready channel. The arbiter grants one request per cycle, computes the result with the shared datapath, and holds it in a single output register with result flags and the requester ID. It sits between client datapaths and the one arithmetic unit they share, replacing per-client adders.

## Interface
- `W`, default 8: operand/result width in bits (W ≥ 2).

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `req0_valid`  in  1  requester 0 has an operation
- `req0_ready`  out  1  requester 0 operation accepted this cycle
- `req0_a`, `req0_b`  in  W  requester 0 operands
- `req0_sub`  in  1  requester 0: 1 = a−b, 0 = a+b
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sub`: same as the requester 0 signals, for requester 1
- `res_valid`  out  1  output register holds a result
- `res_ready`  in  1  consumer takes result this cycle
- `res_y`  out  W  result, modulo 2^W
- `res_id`  out  1  requester that issued the result
- `res_cout`  out  1  add: unsigned carry out; sub: borrow (1 when a < b unsigned)
- `res_ovf`  out  1  two's-complement signed overflow

## Operation
- **Handshake.**
  - A transfer occurs on any channel when valid and ready are both 1 at a rising edge.
  - Requesters hold valid and operands stable until accepted.
  - The consumer may change `res_ready` freely.
- **Output register states.**
  - EMPTY: `res_valid` = 0.
  - FULL: `res_valid` = 1.
  - EMPTY → FULL on accept.
  - FULL → EMPTY on drain with no accept.
  - FULL → FULL on drain plus accept in the same cycle, which loads the new result.
- **Accept enable.** `can_accept` = !`res_valid` | `res_ready`.
- **Grant.** Combinational.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted last is granted.
  - `reqN_ready` = `grantN` & `can_accept`.
  - At most one ready is 1 in any cycle.
  - `reqN_ready` may depend on the other requester's valid.
  - `reqN_ready` never depends on `reqN_valid` of the same port.
- **Round-robin pointer.** `last` updates only on an accepted transfer, to the accepted ID.
- **Arithmetic.**
  - Computed on a W+1-bit extension.
  - Add: {`cout`,y} = a + b.
  - Sub: y = a − b, `cout` = borrow.
  - `ovf`, add: a[W-1] == b[W-1] and y[W-1] != a[W-1].
  - `ovf`, sub: a[W-1] != b[W-1] and y[W-1] != a[W-1].
- **Output stability.** `res_y`, `res_id`, `res_cout` and `res_ovf` change only on accept; they are stable while FULL and not drained.
- **Idle.** No requester valid: nothing is accepted, and `last` and all outputs hold.

## Timing
- **Reset (`rst_n` low, asynchronous).**
  - `res_valid` = 0, `res_y` = 0, `res_id` = 0, `res_cout` = 0, `res_ovf` = 0.
  - `last` = 1, so requester 0 wins the first contended grant.
  - `req0_ready` = `req1_ready` = 0 while `rst_n` is low.
- **Reset mid-operation.** A held result is discarded immediately, with no drain. Behaviour after release is identical to power-up.
- **Latency.** An operation accepted at edge k is visible on `res_*` with `res_valid` = 1 from just after edge k: 1 cycle.
- **Throughput.** One operation per cycle while `res_ready` = 1. Two continuously valid requesters alternate 0,1,0,1.
- **Backpressure.** FULL with `res_ready` = 0 forces both readies to 0. No request is lost or duplicated.
- **Drain plus accept in the same cycle.** The old result is consumed and the new one loaded at the same edge, with no bubble.
- **Fairness.** A continuously valid requester is granted within 2 accepts.

## Test plan
- **Add.** After reset, `req0` a=8'h05, b=8'h03, sub=0, `res_ready`=1 → next cycle `res_valid`=1, `res_y`=8'h08, `res_id`=0, `res_cout`=0, `res_ovf`=0.
- **Add, carry and overflow.**
  - `req1` a=8'h7F + 8'h01 → `res_y`=8'h80, `res_ovf`=1, `res_cout`=0, `res_id`=1.
  - a=8'hFF + 8'h01 → `res_y`=8'h00, `res_cout`=1, `res_ovf`=0.
- **Subtract, borrow and overflow.**
  - sub a=8'h03, b=8'h05 → `res_y`=8'hFE, `res_cout`=1, `res_ovf`=0.
  - sub a=8'h80, b=8'h01 → `res_y`=8'h7F, `res_ovf`=1, `res_cout`=0.
- **Contention.** Both requesters valid continuously with distinct operands, `res_ready`=1, for 6 cycles → `res_id` sequence 0,1,0,1,0,1, with exactly one ready per cycle, each result matching its issuer.
- **Backpressure.** Fill the output register, then hold `res_ready`=0 for 3 cycles with both requesters valid → `res_*` constant, both readies 0. Then raise `res_ready` → drain and new accept occur at the same edge, `res_valid` stays 1.
- **Reset mid-operation.** Pulse `rst_n` low for a half cycle while `res_valid`=1 → `res_valid` falls without waiting for an edge and all outputs go to 0. After release, with both requesters valid, `res_id`=0 first.
